// File: rtl/move_sequencer_pkg.sv
// Shared types and constants for the 2048 move sequencer: tile/board types,
// direction and state encodings, spawn LFSR taps and goal decoding.
package game_2048_pkg;

  typedef logic [11:0] tile_t;
  typedef tile_t [3:0][3:0] board_t;

  // Encoded so a direction equals the index of its (active-low) button bit.
  typedef enum logic [1:0] {
    RIGHT = 2'd0,
    UP    = 2'd1,
    DOWN  = 2'd2,
    LEFT  = 2'd3
  } dir_t;

  typedef enum logic [2:0] {
    INIT   = 3'd0,
    IDLE   = 3'd1,
    MERGE  = 3'd2,
    SPAWN  = 3'd3,
    CHECK  = 3'd4,
    COMMIT = 3'd5,
    HALT   = 3'd6
  } seq_state_t;

  // Taps 16,14,13,11 as bit positions 15,13,12,10.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  localparam int GOAL_MIN_EXP = 4;
  localparam int GOAL_MAX_EXP = 11;

  function automatic tile_t goal_of(input logic [3:0] g);
    if (int'(g) >= GOAL_MIN_EXP && int'(g) <= GOAL_MAX_EXP) begin
      return tile_t'(1) << g;
    end
    return tile_t'(2048);
  endfunction

endpackage

// File: rtl/move_sequencer_if.sv
// Board-side bundle between the move sequencer (master) and the game state
// register / display logic (slave).
interface move_sequencer_if #(
  parameter int SCORE_W = 16
);
  import game_2048_pkg::*;

  logic [3:0]         buttons;
  logic [3:0]         switches;
  board_t             matrix_q;
  board_t             matrix_d;
  logic               commit;
  logic               busy;
  logic               won;
  logic               lost;
  logic [SCORE_W-1:0] score;
  logic [2:0]         fsm_state;

  // commit is a valid-only strobe with no ready: matrix_d is valid exactly in
  // the cycle commit=1 and the state register must load it on that edge.
  modport master (
    input  buttons, switches, matrix_q,
    output matrix_d, commit, busy, won, lost, score, fsm_state
  );

  modport slave (
    output buttons, switches, matrix_q,
    input  matrix_d, commit, busy, won, lost, score, fsm_state
  );

endinterface

// File: rtl/move_sequencer_line_merge.sv
// Combinational 2048 line merge: slide nonzero tiles toward index 0, then merge
// equal neighbours once each, scanning from index 0.
module tile_line_merge
  import game_2048_pkg::*;
(
  input  tile_t [3:0] tiles,
  output tile_t [3:0] merged,
  output logic        changed,
  output logic [12:0] score_add
);

  tile_t [3:0] comp;
  logic  [2:0] cnt;
  tile_t       dbl0, dbl1, dbl2;
  logic        m01, m12, m23;

  always_comb begin
    comp = '0;
    cnt  = '0;
    for (int i = 0; i < 4; i++) begin
      if (tiles[i] != '0) begin
        comp[cnt[1:0]] = tiles[i];
        cnt = cnt + 3'd1;
      end
    end
  end

  assign dbl0 = comp[0] + comp[0];
  assign dbl1 = comp[1] + comp[1];
  assign dbl2 = comp[2] + comp[2];
  assign m01  = (comp[0] != '0) && (comp[0] == comp[1]);
  assign m12  = (comp[1] != '0) && (comp[1] == comp[2]);
  assign m23  = (comp[2] != '0) && (comp[2] == comp[3]);

  // Zeros sit at the tail after compaction, so every merge choice is one of
  // the few cases below.
  always_comb begin
    merged    = '0;
    score_add = '0;
    if (m01) begin
      merged[0] = dbl0;
      score_add = {1'b0, dbl0};
      if (m23) begin
        merged[1] = dbl2;
        score_add = score_add + {1'b0, dbl2};
      end else begin
        merged[1] = comp[2];
        merged[2] = comp[3];
      end
    end else begin
      merged[0] = comp[0];
      if (m12) begin
        merged[1] = dbl1;
        merged[2] = comp[3];
        score_add = {1'b0, dbl1};
      end else begin
        merged[1] = comp[1];
        if (m23) begin
          merged[2] = dbl2;
          score_add = {1'b0, dbl2};
        end else begin
          merged[2] = comp[2];
          merged[3] = comp[3];
        end
      end
    end
  end

  assign changed = (merged != tiles);

endmodule

// File: rtl/move_sequencer.sv
// Sequences one 2048 move: button start detection, four merge passes through a
// shared line merger, LFSR tile spawn, win/loss check and a one-cycle commit.
module move_sequencer
  import game_2048_pkg::*;
#(
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter int          SCORE_W   = 16
) (
  input  logic             clk,
  input  logic             rst_game,
  move_sequencer_if.master bus
);

  seq_state_t         state, state_nxt;
  dir_t               dir, start_dir;
  logic [1:0]         line;
  logic               changed_acc, init_mode, first_done, cap;
  board_t             board;
  logic [SCORE_W-1:0] score;
  logic               won, lost;
  logic [15:0]        lfsr;
  logic [3:0]         sync1, sync2, prev;
  logic [3:0]         idx, cur_idx;
  tile_t              val, cur_val, goal;
  logic               start, spawn_hit, any_win, any_move;
  tile_t [3:0]        line_q, line_m;
  logic               line_changed;
  logic [12:0]        score_add;
  logic [SCORE_W:0]   score_sum;

  // A start needs exactly one button low now and all released the cycle before.
  always_comb begin
    start     = 1'b0;
    start_dir = LEFT;
    if (prev == 4'hF) begin
      case (sync2)
        4'b0111: begin start = 1'b1; start_dir = LEFT;  end
        4'b1011: begin start = 1'b1; start_dir = DOWN;  end
        4'b1101: begin start = 1'b1; start_dir = UP;    end
        4'b1110: begin start = 1'b1; start_dir = RIGHT; end
        default: ;
      endcase
    end
  end

  // Each line is read starting from the edge the tiles slide toward.
  always_comb begin
    line_q = '0;
    for (int k = 0; k < 4; k++) begin
      case (dir)
        LEFT:    line_q[k] = board[line][2'(k)];
        RIGHT:   line_q[k] = board[line][2'(3 - k)];
        UP:      line_q[k] = board[2'(k)][line];
        default: line_q[k] = board[2'(3 - k)][line];
      endcase
    end
  end

  tile_line_merge u_merge (
    .tiles     (line_q),
    .merged    (line_m),
    .changed   (line_changed),
    .score_add (score_add)
  );

  assign score_sum = {1'b0, score} + (SCORE_W + 1)'(score_add);

  // The first spawn cycle uses the live LFSR so an empty first cell costs one cycle.
  assign cur_idx   = cap ? lfsr[3:0] : idx;
  assign cur_val   = cap ? ((lfsr[7:4] == 4'd0) ? tile_t'(4) : tile_t'(2)) : val;
  assign spawn_hit = (state == SPAWN) && (board[cur_idx[3:2]][cur_idx[1:0]] == '0);
  assign goal      = goal_of(bus.switches);

  always_comb begin
    any_win  = 1'b0;
    any_move = 1'b0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (board[r][c] >= goal) any_win = 1'b1;
        if (board[r][c] == '0) any_move = 1'b1;
      end
      for (int c = 0; c < 3; c++) begin
        if (board[r][c] == board[r][c+1]) any_move = 1'b1;
        if (board[c][r] == board[c+1][r]) any_move = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_game) state <= INIT;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      INIT:   state_nxt = SPAWN;
      IDLE: begin
        if (won || lost) state_nxt = HALT;
        else if (start)  state_nxt = MERGE;
      end
      MERGE: begin
        if (line == 2'd3) state_nxt = (changed_acc || line_changed) ? SPAWN : IDLE;
      end
      SPAWN: begin
        if (spawn_hit) begin
          if (!init_mode)      state_nxt = CHECK;
          else if (first_done) state_nxt = COMMIT;
          else                 state_nxt = SPAWN;
        end
      end
      CHECK:  state_nxt = COMMIT;
      COMMIT: state_nxt = (won || lost) ? HALT : IDLE;
      HALT:   state_nxt = HALT;
      default: state_nxt = INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_game) begin
      board       <= '0;
      score       <= '0;
      won         <= 1'b0;
      lost        <= 1'b0;
      lfsr        <= LFSR_SEED;
      sync1       <= 4'hF;
      sync2       <= 4'hF;
      prev        <= 4'hF;
      dir         <= LEFT;
      line        <= '0;
      changed_acc <= 1'b0;
      cap         <= 1'b1;
      idx         <= '0;
      val         <= '0;
      init_mode   <= 1'b1;
      first_done  <= 1'b0;
    end else begin
      lfsr  <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
      sync1 <= bus.buttons;
      sync2 <= sync1;
      prev  <= sync2;
      cap   <= !((state == SPAWN) && !spawn_hit);
      case (state)
        INIT: begin
          init_mode  <= 1'b1;
          first_done <= 1'b0;
        end
        IDLE: begin
          if (state_nxt == MERGE) begin
            dir         <= start_dir;
            board       <= bus.matrix_q;
            line        <= '0;
            changed_acc <= 1'b0;
            init_mode   <= 1'b0;
          end
        end
        MERGE: begin
          for (int k = 0; k < 4; k++) begin
            case (dir)
              LEFT:    board[line][2'(k)]     <= line_m[k];
              RIGHT:   board[line][2'(3 - k)] <= line_m[k];
              UP:      board[2'(k)][line]     <= line_m[k];
              default: board[2'(3 - k)][line] <= line_m[k];
            endcase
          end
          line        <= line + 2'd1;
          changed_acc <= changed_acc | line_changed;
          score       <= score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
        end
        SPAWN: begin
          if (spawn_hit) begin
            board[cur_idx[3:2]][cur_idx[1:0]] <= cur_val;
            first_done <= 1'b1;
          end else begin
            idx <= cur_idx + 4'd1;
            val <= cur_val;
          end
        end
        CHECK: begin
          won  <= won | any_win;
          lost <= lost | !any_move;
        end
        default: ;
      endcase
    end
  end

  assign bus.matrix_d  = board;
  assign bus.commit    = (state == COMMIT);
  assign bus.busy      = (state != IDLE) && (state != HALT);
  assign bus.won       = won;
  assign bus.lost      = lost;
  assign bus.score     = score;
  assign bus.fsm_state = state;

endmodule

// File: tb/tb_move_sequencer.sv
// Bench for move_sequencer: directed and random moves checked against a
// cell-array model of the 2048 rules, spawn LFSR and move latency.
module tb_move_sequencer;
  import game_2048_pkg::*;

  localparam logic [15:0] SEED = 16'hACE1;

  logic clk = 1'b0;
  logic rst_game = 1'b0;
  always #5 clk = ~clk;

  move_sequencer_if #(.SCORE_W(16)) bus();

  move_sequencer #(.LFSR_SEED(SEED), .SCORE_W(16)) dut (
    .clk      (clk),
    .rst_game (rst_game),
    .bus      (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  int cur [16];
  int nxt [16];
  int line_in [4];
  int line_out [4];
  int line_score;
  int exp_score;
  int goal_m;
  bit won_m, lost_m;
  logic [15:0] lfsr_m;

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    logic fb;
    fb = v[16-1] ^ v[14-1] ^ v[13-1] ^ v[11-1];
    return {v[14:0], fb};
  endfunction

  always @(posedge clk) begin
    if (!rst_game) lfsr_m <= SEED;
    else           lfsr_m <= lfsr_step(lfsr_m);
  end

  task automatic check(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic board_t pack(input int b[16]);
    board_t r;
    r = '0;
    for (int n = 0; n < 16; n++) r[n/4][n%4] = tile_t'(b[n]);
    return r;
  endfunction

  // d is the button bit: 3 left, 2 down, 1 up, 0 right; k counts from the destination edge.
  function automatic int cell_of(input int d, input int i, input int k);
    case (d)
      3:       return i * 4 + k;
      0:       return i * 4 + (3 - k);
      1:       return k * 4 + i;
      default: return (3 - k) * 4 + i;
    endcase
  endfunction

  function automatic void merge_line();
    int q[$];
    int a, n;
    q = {};
    for (int i = 0; i < 4; i++) if (line_in[i] != 0) q.push_back(line_in[i]);
    for (int i = 0; i < 4; i++) line_out[i] = 0;
    line_score = 0;
    n = 0;
    while (q.size() > 0) begin
      a = q.pop_front();
      if (q.size() > 0 && q[0] == a) begin
        void'(q.pop_front());
        line_out[n] = (2 * a) % 4096;
        line_score += (2 * a) % 4096;
      end else begin
        line_out[n] = a;
      end
      n++;
    end
  endfunction

  function automatic bit predict_move(input int d, output int gain);
    bit chg;
    chg = 1'b0;
    gain = 0;
    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < 4; k++) line_in[k] = cur[cell_of(d, i, k)];
      merge_line();
      for (int k = 0; k < 4; k++) begin
        nxt[cell_of(d, i, k)] = line_out[k];
        if (line_out[k] != line_in[k]) chg = 1'b1;
      end
      gain += line_score;
    end
    return chg;
  endfunction

  function automatic int spawn_into_nxt(input logic [15:0] v);
    int start, v_tile, c;
    start  = int'(v[3:0]);
    v_tile = (v[7:4] == 4'd0) ? 4 : 2;
    for (int s = 0; s < 16; s++) begin
      c = (start + s) % 16;
      if (nxt[c] == 0) begin
        nxt[c] = v_tile;
        return s + 1;
      end
    end
    return 99;
  endfunction

  function automatic void eval_end();
    bit stuck;
    stuck = 1'b1;
    for (int n = 0; n < 16; n++) begin
      if (nxt[n] >= goal_m) won_m = 1'b1;
      if (nxt[n] == 0) stuck = 1'b0;
      if ((n % 4) < 3 && nxt[n] == nxt[n+1]) stuck = 1'b0;
      if ((n / 4) < 3 && nxt[n] == nxt[n+4]) stuck = 1'b0;
    end
    if (stuck) lost_m = 1'b1;
  endfunction

  task automatic set_goal(input int g);
    bus.switches = 4'(g);
    goal_m = (g >= 4 && g <= 11) ? (1 << g) : 2048;
  endtask

  task automatic load_board(input int r0[4], input int r3[4]);
    for (int n = 0; n < 16; n++) cur[n] = 0;
    for (int c = 0; c < 4; c++) begin
      cur[c] = r0[c];
      cur[12 + c] = r3[c];
    end
    bus.matrix_q = pack(cur);
  endtask

  task automatic do_reset();
    int k, s2, nz, odd;
    logic [15:0] cap1, cap2;
    rst_game = 1'b0;
    bus.buttons = 4'hF;
    repeat (3) @(negedge clk);
    check("rst_state", bus.fsm_state, INIT);
    check("rst_commit", bus.commit, 0);
    check("rst_score", bus.score, 0);
    check("rst_won", bus.won, 0);
    check("rst_lost", bus.lost, 0);
    check("rst_busy", bus.busy, 1);
    check("rst_board", bus.matrix_d, 0);
    exp_score = 0;
    won_m = 1'b0;
    lost_m = 1'b0;
    cap1 = '0;
    cap2 = '0;
    rst_game = 1'b1;
    for (k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 1) cap1 = lfsr_m;
      if (k == 2) cap2 = lfsr_m;
      if (bus.commit) break;
    end
    for (int n = 0; n < 16; n++) nxt[n] = 0;
    void'(spawn_into_nxt(cap1));
    s2 = spawn_into_nxt(cap2);
    check("init_latency", k, 2 + s2);
    check("init_board", bus.matrix_d, pack(nxt));
    nz = 0;
    odd = 0;
    for (int n = 0; n < 16; n++) begin
      if (bus.matrix_d[n/4][n%4] != 0) nz++;
      if (!(bus.matrix_d[n/4][n%4] inside {12'd0, 12'd2, 12'd4})) odd++;
    end
    check("init_tiles", nz, 2);
    check("init_values", odd, 0);
    check("init_score", bus.score, 0);
    cur = nxt;
    bus.matrix_q = pack(cur);
    @(negedge clk);
    check("init_idle", bus.fsm_state, IDLE);
    check("init_pulse", bus.commit, 0);
  endtask

  task automatic do_move(input logic [3:0] btns, input string tag);
    int d, gain, k, s, extra;
    bit valid, chg;
    logic [15:0] cap;
    valid = ($countones(~btns) == 1) && !(won_m || lost_m);
    d = 0;
    for (int i = 0; i < 4; i++) if (!btns[i]) d = i;
    gain = 0;
    chg = valid ? predict_move(d, gain) : 1'b0;
    cap = '0;
    bus.buttons = btns;
    if (chg) begin
      for (k = 1; k <= 40; k++) begin
        @(negedge clk);
        if (k == 7) cap = lfsr_m;
        if (bus.commit) break;
      end
      s = spawn_into_nxt(cap);
      exp_score = (exp_score + gain > 65535) ? 65535 : exp_score + gain;
      eval_end();
      check({tag, "_latency"}, k, 8 + s);
      check({tag, "_board"}, bus.matrix_d, pack(nxt));
      check({tag, "_busy"}, bus.busy, 1);
      check({tag, "_score"}, bus.score, exp_score);
      check({tag, "_won"}, bus.won, won_m);
      check({tag, "_lost"}, bus.lost, lost_m);
      cur = nxt;
      bus.matrix_q = pack(cur);
    end
    extra = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.commit) extra++;
    end
    check({tag, "_extra_commits"}, extra, 0);
    bus.buttons = 4'hF;
    repeat (4) @(negedge clk);
    check({tag, "_state"}, bus.fsm_state, (won_m || lost_m) ? HALT : IDLE);
    check({tag, "_score_after"}, bus.score, exp_score);
    if (valid) check({tag, "_board_after"}, bus.matrix_d, pack(cur));
  endtask

  initial begin
    int dr;
    logic [3:0] rb;
    bus.buttons = 4'hF;
    bus.matrix_q = '0;
    set_goal(11);
    do_reset();

    load_board('{2, 2, 2, 2}, '{0, 0, 0, 0});
    do_move(4'b0111, "left_2222");
    check("left_2222_c0", bus.matrix_d[0][0], 4);
    check("left_2222_c1", bus.matrix_d[0][1], 4);
    check("left_2222_sum", bus.score, 8);

    load_board('{4, 0, 4, 8}, '{0, 0, 0, 0});
    do_move(4'b1110, "right_4048");
    check("right_4048_c2", bus.matrix_d[0][2], 8);
    check("right_4048_c3", bus.matrix_d[0][3], 8);
    check("right_4048_sum", bus.score, 16);

    load_board('{2, 2, 4, 0}, '{0, 0, 0, 0});
    do_move(4'b0111, "left_2240");
    check("left_2240_c0", bus.matrix_d[0][0], 4);
    check("left_2240_c1", bus.matrix_d[0][1], 4);
    check("left_2240_sum", bus.score, 20);

    load_board('{2, 4, 8, 16}, '{4, 2, 0, 0});
    do_move(4'b0111, "left_blocked");
    check("left_blocked_sum", bus.score, 20);

    do_move(4'b0110, "two_buttons");

    // Two cells stay empty so a random move can never end the game.
    repeat (8) begin
      for (int n = 0; n < 16; n++) begin
        dr = int'($urandom_range(0, 7));
        cur[n] = (dr < 4) ? 0 : (2 << (dr - 4));
      end
      cur[$urandom_range(0, 7)] = 0;
      cur[$urandom_range(8, 15)] = 0;
      bus.matrix_q = pack(cur);
      rb = ~(4'b0001 << $urandom_range(0, 3));
      do_move(rb, "random");
    end

    set_goal(4);
    load_board('{8, 8, 0, 0}, '{0, 0, 0, 0});
    do_move(4'b0111, "win16");
    check("win16_won", bus.won, 1);
    check("win16_halt", bus.fsm_state, HALT);
    do_move(4'b1110, "halt_press");

    set_goal(11);
    do_reset();
    load_board('{2, 2, 0, 0}, '{4, 4, 0, 0});
    bus.buttons = 4'b0111;
    repeat (3) @(negedge clk);
    check("abort_in_merge", bus.fsm_state, MERGE);
    do_reset();

    for (int c = 0; c < 4; c++) begin
      cur[c]     = (c % 2 == 0) ? 8 : 16;
      cur[4 + c] = (c % 2 == 0) ? 16 : 8;
      cur[8 + c] = (c % 2 == 0) ? 8 : 16;
    end
    cur[12] = 0;
    cur[13] = 32;
    cur[14] = 64;
    cur[15] = 128;
    bus.matrix_q = pack(cur);
    do_move(4'b0111, "lose");
    check("lose_lost", bus.lost, 1);
    check("lose_halt", bus.fsm_state, HALT);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/move_sequencer.md
Name: move_sequencer

Overview:
- Controller that sequences one 2048 move on the 4x4 tile matrix:
  - button edge detection;
  - four line passes through one shared line-merge unit;
  - pseudo-random tile spawn;
  - win/loss evaluation;
  - single-cycle commit of the new board to the matrix state register.
- Sits between the button inputs and the game's current-state register. VGA and 7-segment logic read its `won`, `lost`, `score` and `fsm_state` outputs.

Parameters:
- LFSR_SEED, 16'hACE1, reset value of the spawn LFSR (must be nonzero).
- SCORE_W, 16, score width; score saturates at all-ones.

Ports:
- clk  in  1  system clock
- rst_game  in  1  synchronous, active-low reset
- buttons  in  4  active-low pushbuttons: [3] left, [2] down, [1] up, [0] right
- switches  in  4  goal exponent g
- matrix_q  in  12x[3:0][3:0]  current board, indexed [row][col]; row 0 = top, col 0 = left
- matrix_d  out  12x[3:0][3:0]  working board; valid while commit=1
- commit  out  1  one-cycle pulse; the state register loads matrix_d
- busy  out  1  high in every state except IDLE/HALT
- won  out  1  sticky; set when any tile >= goal
- lost  out  1  sticky; set when no empty cell and no equal orthogonal neighbours
- score  out  SCORE_W  accumulated merge sums
- fsm_state  out  3  current state encoding from the package

Behaviour:
- Reset (rst_game=0 at a clk edge):
  - state=INIT; working board cleared to 0; score=0; won=lost=commit=0.
  - LFSR=LFSR_SEED; sync flops = 4'b1111.
  - Reset mid-move aborts with no commit.
- LFSR:
  - 16-bit Fibonacci, taps 16,14,13,11; advances every cycle outside reset.
- Buttons:
  - Two-flop synchroniser, then a registered previous sample.
  - start = exactly one synced button low AND previous sample all high.
  - Two or more buttons low: ignored.
  - All buttons must be released before the next start.
- Goal: goal = 1<<g for g in 4..11; any other g gives goal = 2048.
- Tile values are stored directly (0, 2, 4 … 2048); merge sums use 12-bit arithmetic.
- States:
  - INIT: spawn two tiles (two SPAWN passes), then COMMIT, then IDLE.
  - IDLE: on start, latch direction, copy matrix_q into the working board, go to MERGE with line=0.
    - If won or lost is set, stay in HALT instead.
  - MERGE: exactly 4 cycles, line 0..3, one line per cycle through tile_line_merge. Lines are ordered from the destination edge:
    - left: row i, col 0..3
    - right: row i, col 3..0
    - up: col i, row 0..3
    - down: col i, row 3..0
    - Each cycle writes back the line, ORs `changed`, and adds score_add to score (saturating).
  - After MERGE:
    - changed=0: return to IDLE; no commit; score unchanged (score_add is necessarily 0).
    - changed=1: go to SPAWN.
  - SPAWN:
    - First cycle captures idx=lfsr[3:0] and val = (lfsr[7:4]==0) ? 4 : 2.
    - Scans cells idx, idx+1 … mod 16 (cell n = row n[3:2], col n[1:0]), one per cycle.
    - Writes val into the first zero cell; at most 16 cycles.
    - An empty cell always exists after a changing move.
  - CHECK (1 cycle): evaluate won/lost on the working board.
  - COMMIT (1 cycle): commit=1; matrix_d = working board; next state is HALT if won|lost, else IDLE.
  - HALT: terminal until reset; buttons ignored.
- tile_line_merge rules:
  - Compact nonzero tiles toward index 0.
  - Merge equal adjacent pairs scanning from index 0; each tile merges at most once.
  - Pad with zeros.
  - changed = output != input; score_add = sum of merged results.
- Latency: a changing move commits 4 (MERGE) + 1..16 (SPAWN) + 1 (CHECK) + 1 (COMMIT) cycles after leaving IDLE.

Decomposition:
- Package game_2048_pkg:
  - tile_t (logic [11:0]);
  - dir_t enum (LEFT, DOWN, UP, RIGHT);
  - seq_state_t enum, 3 bits (INIT, IDLE, MERGE, SPAWN, CHECK, COMMIT, HALT);
  - LFSR tap constant;
  - GOAL_MIN_EXP=4, GOAL_MAX_EXP=11.
- One combinational sub-module, tile_line_merge:
  - inputs: 4 tile_t;
  - outputs: 4 tile_t, changed, score_add [12:0].

Test Plan:
- Reset with LFSR_SEED default → commit pulses once after INIT. matrix_d holds exactly two nonzero tiles, each 2 or 4; score=0.
- Row 0 = [2,2,2,2], press left → row 0 = [4,4,0,0] plus one spawned tile elsewhere; score += 8; one commit pulse.
- Row 0 = [4,0,4,8], press right → row 0 = [0,0,8,8]. Row [2,2,4,0] with left → [4,4,0,0], no double merge.
- Board with no possible left move, press left → no commit; returns to IDLE; board and score unchanged.
- Buttons 4'b0110 (two pressed) → ignored. Holding left through two moves' worth of cycles → exactly one move.
- switches=4, a merge creates a 16 → won=1, then HALT; further presses give no commit. A full board with no equal neighbours after spawn → lost=1. rst_game=0 during MERGE → INIT, no commit from the aborted move.
